data_cache_assoc: RTL and testbench
===================================

DATA_CACHE_ASSOC -- requirements
Module: data_cache_assoc

Interface
REQ-001 SHALL have parameter SET_BITS, default 3, log2 of the number of sets (8 sets).
REQ-002 SHALL have parameter LINE_WORDS, default 4, number of 32-bit words per line, a power of 2 and at least 2.
REQ-003 SHALL derive OFF_BITS = log2(LINE_WORDS)+2 and TAG_BITS = 32-SET_BITS-OFF_BITS; these are not user-settable.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; clock: clock  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have port read  in  4  [3] = load request, [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-007 SHALL have port write  in  3  [2] = store request, [1:0] = size (00 SB, 01 SH, 10 SW).
REQ-008 SHALL have port address  in  32  byte address.
REQ-009 SHALL have port writedata  in  32  store data, right-aligned.
REQ-010 SHALL have port readdata  out  32  extended load result.
REQ-011 SHALL have port busywait  out  1  high = requester stalls.
REQ-012 SHALL have port misaligned  out  1  high = the current request is illegal and ignored.
REQ-013 SHALL have port mem_read  out  1  line fetch request.
REQ-014 SHALL have port mem_write  out  1  line writeback request.
REQ-015 SHALL have port mem_address  out  32-OFF_BITS  line address.
REQ-016 SHALL have port mem_writedata  out  32*LINE_WORDS  victim line.
REQ-017 SHALL have port mem_readdata  in  32*LINE_WORDS  fetched line.
REQ-018 SHALL have port mem_busywait  in  1  memory busy.

Function
REQ-019 SHALL be a 2-way set-associative, write-back, write-allocate cache with one LRU bit per set.
REQ-020 SHALL decode address as tag [31:32-TAG_BITS], set [OFF_BITS+SET_BITS-1:OFF_BITS], word [OFF_BITS-1:2], byte [1:0].
REQ-021 SHALL treat read[3] and write[2] both high, read funct3 011/110/111, and write size 11 as illegal: no access, misaligned=1, busywait=0.
REQ-022 SHALL treat LH/LHU/SH with byte[0]=1, and LW/SW with byte!=0, as illegal, with the same response as REQ-021.
REQ-023 SHALL on a hit in IDLE drive busywait=0 combinationally and drive readdata combinationally in the same cycle.
REQ-024 SHALL on a store hit merge the enabled bytes into the hit word at the next rising edge and set that way's dirty bit.
REQ-025 SHALL on every hit set lru[set] to the way that did not hit.
REQ-026 SHALL extend loads as follows: LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified; readdata=0 when there is no legal load hit.
REQ-027 SHALL on a miss drive busywait=1 from the request cycle until the cycle the eventual hit is served.
REQ-028 SHALL select the victim as an invalid way if one exists (way0 preferred), otherwise way lru[set].
REQ-029 SHALL implement FSM states IDLE, WRITEBACK, FETCH.
REQ-030 SHALL transition IDLE->WRITEBACK on a miss with a dirty victim, and IDLE->FETCH on a miss with a clean or invalid victim.
REQ-031 SHALL in WRITEBACK drive mem_write=1, mem_address={victim tag,set}, mem_writedata=victim line; on a rising edge with mem_busywait=0, clear the victim's dirty bit and move to FETCH.
REQ-032 SHALL in FETCH drive mem_read=1 and mem_address={tag,set}; on a rising edge with mem_busywait=0, write the line, tag, valid=1, dirty=0 into the victim and return to IDLE.
REQ-033 SHALL serve the request as an ordinary hit in the IDLE cycle after FETCH, so the miss penalty is memory latency + 1 cycle.
REQ-034 SHALL keep mem_read and mem_write never high together and both low in IDLE.
REQ-035 SHALL rely on the requester holding read/write/address/writedata stable while busywait=1; behaviour on changed inputs is undefined.

Reset
REQ-036 SHALL on reset low, immediately and asynchronously: state=IDLE, all valid/dirty/lru bits=0, mem_read=mem_write=0.
REQ-037 SHALL on reset low drive busywait=0, misaligned=0 and readdata=0; data and tag arrays are not reset.
REQ-038 SHALL on reset mid-miss abandon the transfer without installing a line; the requester re-issues after reset release.

Structure
REQ-039 SHALL place funct3/size encodings and the FSM state encoding in shared package cache_pkg.
REQ-040 SHALL implement load extraction/extension and store byte-mask/shift in sub-module cache_byte_align.

Verification
REQ-041 SHALL cover: cold LW at 0x40, memory returns line {D3,D2,D1,D0} after 3 busy cycles -> mem_read for 4 cycles, mem_address=0x004, readdata=D0 in the following cycle.
REQ-042 SHALL cover: SB 0xAB at 0x41, then LBU at 0x41 -> 0x000000AB; LB at 0x41 -> 0xFFFFFFAB; dirty set.
REQ-043 SHALL cover: fill both ways of set 4 (0x40, 0x440), touch 0x40, then access 0x840 -> victim is way holding 0x440.
REQ-044 SHALL cover: miss with a dirty victim -> WRITEBACK with the old line and old address precedes FETCH, and no overlap of mem_read/mem_write.
REQ-045 SHALL cover: LW at 0x42 and SH at 0x43 -> misaligned=1, busywait=0, no memory traffic, cache contents unchanged.
REQ-046 SHALL cover: reset asserted in FETCH -> mem_read drops without waiting for clock, and a subsequent access to the same address misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared encodings for the associative data cache: load/store size codes,
// controller state codes and the legality checks applied to each request.
package cache_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'b00;
    localparam state_t ST_WRITEBACK = 2'b01;
    localparam state_t ST_FETCH     = 2'b10;

    function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] bo);
        case (f3)
            F3_LB, F3_LBU: load_ok = 1'b1;
            F3_LH, F3_LHU: load_ok = ~bo[0];
            F3_LW:         load_ok = (bo == 2'b00);
            default:       load_ok = 1'b0;
        endcase
    endfunction

    function automatic logic store_ok(input logic [1:0] sz, input logic [1:0] bo);
        case (sz)
            SZ_B:    store_ok = 1'b1;
            SZ_H:    store_ok = ~bo[0];
            SZ_W:    store_ok = (bo == 2'b00);
            default: store_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cache_byte_align.sv
// Byte lane handling between a 32-bit cache word and the requester:
// load extraction with sign/zero extension, store byte enables and lane replication.
module cache_byte_align
    import cache_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  size,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word_in[{byte_off, 3'b000} +: 8];
        sel_half = byte_off[1] ? word_in[31:16] : word_in[15:0];
        case (funct3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LW:   load_data = word_in;
            F3_LBU:  load_data = {24'h0, sel_byte};
            F3_LHU:  load_data = {16'h0, sel_half};
            default: load_data = '0;
        endcase
    end

    // Store data is replicated across lanes so the enables alone pick the target bytes.
    always_comb begin
        case (size)
            SZ_B: begin
                byte_en    = 4'b0001 << byte_off;
                store_data = {4{wdata[7:0]}};
            end
            SZ_H: begin
                byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            SZ_W: begin
                byte_en    = 4'b1111;
                store_data = wdata;
            end
            default: begin
                byte_en    = 4'b0000;
                store_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_cache_assoc.sv
// Two-way set-associative write-back, write-allocate data cache with one LRU bit per set.
//   state        | meaning
//   ST_IDLE      | serve hits combinationally, start a refill on a miss
//   ST_WRITEBACK | write the dirty victim line back to memory
//   ST_FETCH     | fetch the requested line into the victim way
module data_cache_assoc
    import cache_pkg::*;
#(
    parameter int  SET_BITS   = 3,
    parameter int  LINE_WORDS = 4,
    localparam int OFF_BITS   = $clog2(LINE_WORDS) + 2,
    localparam int TAG_BITS   = 32 - SET_BITS - OFF_BITS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [3:0]                read,
    input  logic [2:0]                write,
    input  logic [31:0]               address,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic                      busywait,
    output logic                      misaligned,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [31-OFF_BITS:0]      mem_address,
    output logic [32*LINE_WORDS-1:0]  mem_writedata,
    input  logic [32*LINE_WORDS-1:0]  mem_readdata,
    input  logic                      mem_busywait
);

    localparam int SETS      = 1 << SET_BITS;
    localparam int WORD_BITS = OFF_BITS - 2;
    localparam int LINE_BITS = 32 * LINE_WORDS;

    logic [TAG_BITS-1:0]  tag_q  [2][SETS];
    logic [TAG_BITS-1:0]  tag_d  [2][SETS];
    logic [LINE_BITS-1:0] data_q [2][SETS];
    logic [LINE_BITS-1:0] data_d [2][SETS];
    logic [1:0][SETS-1:0] valid_q, valid_d;
    logic [1:0][SETS-1:0] dirty_q, dirty_d;
    logic [SETS-1:0]      lru_q, lru_d;
    state_t               state_q, state_d;
    logic                 victim_q, victim_d;

    logic [TAG_BITS-1:0]  req_tag;
    logic [SET_BITS-1:0]  req_set;
    logic [WORD_BITS-1:0] req_word;
    logic [WORD_BITS+4:0] word_lsb;
    logic [1:0]           byte_off;
    logic                 load_req, store_req, illegal, access;
    logic                 hit0, hit1, hit, hit_way, serve;
    logic                 victim_sel, victim_dirty;
    logic [31:0]          hit_word, load_data, store_data, merged_word;
    logic [3:0]           byte_en;

    assign req_tag   = address[31 -: TAG_BITS];
    assign req_set   = address[OFF_BITS +: SET_BITS];
    assign req_word  = address[2 +: WORD_BITS];
    assign byte_off  = address[1:0];
    assign word_lsb  = {req_word, 5'b00000};

    assign load_req  = read[3];
    assign store_req = write[2];
    assign illegal   = (load_req & store_req)
                     | (load_req & ~load_ok(read[2:0], byte_off))
                     | (store_req & ~store_ok(write[1:0], byte_off));
    assign access    = (load_req | store_req) & ~illegal;

    assign hit0    = valid_q[0][req_set] && (tag_q[0][req_set] == req_tag);
    assign hit1    = valid_q[1][req_set] && (tag_q[1][req_set] == req_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = ~hit0;
    assign serve   = (state_q == ST_IDLE) && access && hit;

    assign hit_word = data_q[hit_way][req_set][word_lsb +: 32];

    // Invalid ways are filled first so LRU only decides once the set is full.
    assign victim_sel   = ~valid_q[0][req_set] ? 1'b0 :
                          ~valid_q[1][req_set] ? 1'b1 : lru_q[req_set];
    assign victim_dirty = dirty_q[victim_sel][req_set];

    cache_byte_align u_align (
        .funct3     (read[2:0]),
        .size       (write[1:0]),
        .byte_off   (byte_off),
        .word_in    (hit_word),
        .wdata      (writedata),
        .load_data  (load_data),
        .byte_en    (byte_en),
        .store_data (store_data)
    );

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged_word[8*b +: 8] = byte_en[b] ? store_data[8*b +: 8] : hit_word[8*b +: 8];
        end
    end

    // Outputs are gated by reset so they fall immediately, without waiting for a clock.
    always_comb begin
        readdata      = (reset && serve && load_req) ? load_data : 32'h0;
        busywait      = reset && ((state_q != ST_IDLE) || (access && !hit));
        misaligned    = reset && (load_req || store_req) && illegal;
        mem_read      = reset && (state_q == ST_FETCH);
        mem_write     = reset && (state_q == ST_WRITEBACK);
        mem_address   = (state_q == ST_WRITEBACK) ? {tag_q[victim_q][req_set], req_set}
                                                  : {req_tag, req_set};
        mem_writedata = data_q[victim_q][req_set];
    end

    always_comb begin
        tag_d    = tag_q;
        data_d   = data_q;
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        lru_d    = lru_q;
        state_d  = state_q;
        victim_d = victim_q;
        case (state_q)
            ST_IDLE: begin
                if (access && hit) begin
                    lru_d[req_set] = ~hit_way;
                    if (store_req) begin
                        data_d[hit_way][req_set][word_lsb +: 32] = merged_word;
                        dirty_d[hit_way][req_set] = 1'b1;
                    end
                end else if (access) begin
                    victim_d = victim_sel;
                    state_d  = victim_dirty ? ST_WRITEBACK : ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                if (!mem_busywait) begin
                    dirty_d[victim_q][req_set] = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!mem_busywait) begin
                    data_d[victim_q][req_set]  = mem_readdata;
                    tag_d[victim_q][req_set]   = req_tag;
                    valid_d[victim_q][req_set] = 1'b1;
                    dirty_d[victim_q][req_set] = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            victim_q <= 1'b0;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            lru_q    <= lru_d;
        end
    end

    // Tag and data storage carry no reset; valid bits guard them.
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_data_cache_assoc.sv
// Directed bench for data_cache_assoc: table of hit vectors plus miss, eviction,
// writeback and reset-during-fetch sequences against a small line memory model.
module tb_data_cache_assoc;

    logic          clock;
    logic          reset;
    logic [3:0]    read;
    logic [2:0]    write;
    logic [31:0]   address;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          busywait;
    logic          misaligned;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_address;
    logic [127:0]  mem_writedata;
    logic [127:0]  mem_readdata;
    logic          mem_busywait;

    data_cache_assoc dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .misaligned    (misaligned),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam int LAT = 3;

    int passed = 0;
    int total  = 0;

    logic [127:0] mem_store [logic [27:0]];
    int           busy_cnt = 0;
    int           cyc = 0;
    int           rd_cycles, wr_cycles, overlap, first_rd_cyc, first_wr_cyc;
    logic [27:0]  rd_addr, wb_addr;
    logic [127:0] wb_data;

    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [127:0] l;
        if (mem_store.exists(la)) return mem_store[la];
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ii;
            ii = 4'(i);
            l[32*i +: 32] = {16'hC3A5, la[11:0], ii};
        end
        return l;
    endfunction

    // Memory model and traffic monitor, evaluated away from the active edge.
    always @(negedge clock) begin
        cyc++;
        if (mem_read && mem_write) overlap++;
        if (mem_read) begin
            rd_cycles++;
            rd_addr = mem_address;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (mem_write) begin
            wr_cycles++;
            wb_addr = mem_address;
            wb_data = mem_writedata;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (mem_read || mem_write) begin
            mem_readdata = line_of(mem_address);
            if (busy_cnt == LAT) begin
                mem_busywait = 1'b0;
                busy_cnt = 0;
                if (mem_write) mem_store[mem_address] = mem_writedata;
            end else begin
                mem_busywait = 1'b1;
                busy_cnt++;
            end
        end else begin
            busy_cnt = 0;
            mem_busywait = 1'b0;
        end
    end

    task automatic clear_mon();
        rd_cycles = 0; wr_cycles = 0; overlap = 0;
        first_rd_cyc = -1; first_wr_cyc = -1;
        rd_addr = '0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Called just after a rising edge; returns after the edge that completes the access.
    task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rdat,
                          output logic mis, output int cycles);
        logic done;
        read = rd; write = wr; address = a; writedata = wd;
        cycles = 0; rdat = '0; mis = 1'b0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clock);
            cycles++;
            if (!busywait) begin
                rdat = readdata;
                mis  = misaligned;
                done = 1'b1;
            end
        end
        if (!done) cycles = 999;
        @(posedge clock);
        #1;
        read = 4'b0; write = 3'b0;
    endtask

    typedef struct {
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LBU = 4'b1100, LHU = 4'b1101;
    localparam logic [2:0] SB = 3'b100, SH = 3'b101, SW = 3'b110;

    vec_t        vecs [24];
    logic [31:0] r;
    logic        m;
    int          c;

    initial begin
        vecs[0]  = '{LW,      3'b0, 32'h40, 32'h0,        32'hC3A50040, 1'b0};
        vecs[1]  = '{LW,      3'b0, 32'h44, 32'h0,        32'hC3A50041, 1'b0};
        vecs[2]  = '{LB,      3'b0, 32'h42, 32'h0,        32'hFFFFFFA5, 1'b0};
        vecs[3]  = '{LBU,     3'b0, 32'h42, 32'h0,        32'h000000A5, 1'b0};
        vecs[4]  = '{LH,      3'b0, 32'h42, 32'h0,        32'hFFFFC3A5, 1'b0};
        vecs[5]  = '{LHU,     3'b0, 32'h42, 32'h0,        32'h0000C3A5, 1'b0};
        vecs[6]  = '{LH,      3'b0, 32'h40, 32'h0,        32'h00000040, 1'b0};
        vecs[7]  = '{LB,      3'b0, 32'h43, 32'h0,        32'hFFFFFFC3, 1'b0};
        vecs[8]  = '{4'b0,    SB,   32'h41, 32'hAB,       32'h0,        1'b0};
        vecs[9]  = '{LBU,     3'b0, 32'h41, 32'h0,        32'h000000AB, 1'b0};
        vecs[10] = '{LB,      3'b0, 32'h41, 32'h0,        32'hFFFFFFAB, 1'b0};
        vecs[11] = '{LW,      3'b0, 32'h40, 32'h0,        32'hC3A5AB40, 1'b0};
        vecs[12] = '{4'b0,    SH,   32'h46, 32'h1234BEEF, 32'h0,        1'b0};
        vecs[13] = '{LW,      3'b0, 32'h44, 32'h0,        32'hBEEF0041, 1'b0};
        vecs[14] = '{4'b0,    SW,   32'h4C, 32'h12345678, 32'h0,        1'b0};
        vecs[15] = '{LW,      3'b0, 32'h4C, 32'h0,        32'h12345678, 1'b0};
        vecs[16] = '{LHU,     3'b0, 32'h4E, 32'h0,        32'h00001234, 1'b0};
        vecs[17] = '{LW,      3'b0, 32'h42, 32'h0,        32'h0,        1'b1};
        vecs[18] = '{4'b0,    SH,   32'h43, 32'h5555,     32'h0,        1'b1};
        vecs[19] = '{4'b1011, 3'b0, 32'h40, 32'h0,        32'h0,        1'b1};
        vecs[20] = '{4'b0,    3'b111, 32'h40, 32'h0,      32'h0,        1'b1};
        vecs[21] = '{LW,      SW,   32'h40, 32'h0,        32'h0,        1'b1};
        vecs[22] = '{LHU,     3'b0, 32'h41, 32'h0,        32'h0,        1'b1};
        vecs[23] = '{LW,      3'b0, 32'h40, 32'h0,        32'hC3A5AB40, 1'b0};

        mem_readdata = '0; mem_busywait = 1'b0;
        clear_mon();
        reset = 1'b0; read = 4'b1011; write = 3'b0; address = 32'h40; writedata = '0;
        #2;
        chk("rst_busywait",   busywait,   1'b0);
        chk("rst_misaligned", misaligned, 1'b0);
        chk("rst_readdata",   readdata,   32'h0);
        chk("rst_mem_read",   mem_read,   1'b0);
        chk("rst_mem_write",  mem_write,  1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1; read = 4'b0;
        @(posedge clock); #1;

        clear_mon();
        access(LW, 3'b0, 32'h40, 32'h0, r, m, c);
        chk("cold_rdata",  r, 32'hC3A50040);
        chk("cold_cycles", c, 6);
        chk("cold_rd_cyc", rd_cycles, 4);
        chk("cold_wr_cyc", wr_cycles, 0);
        chk("cold_addr",   rd_addr, 28'h004);

        clear_mon();
        for (int i = 0; i < 24; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, r, m, c);
            chk($sformatf("vec%0d_rdata", i),  r, vecs[i].exp_rd);
            chk($sformatf("vec%0d_mis", i),    m, vecs[i].exp_mis);
            chk($sformatf("vec%0d_cycles", i), c, 1);
        end
        chk("table_no_traffic", rd_cycles + wr_cycles, 0);

        access(LW, 3'b0, 32'h440, 32'h0, r, m, c);
        chk("fill440_rdata",  r, 32'hC3A50440);
        chk("fill440_cycles", c, 6);
        access(LW, 3'b0, 32'h40, 32'h0, r, m, c);
        chk("touch40_cycles", c, 1);
        clear_mon();
        access(LW, 3'b0, 32'h840, 32'h0, r, m, c);
        chk("fill840_rdata",  r, 32'hC3A50840);
        chk("fill840_cycles", c, 6);
        chk("fill840_no_wb",  wr_cycles, 0);
        access(LW, 3'b0, 32'h40, 32'h0, r, m, c);
        chk("keep40_cycles", c, 1);
        chk("keep40_rdata",  r, 32'hC3A5AB40);
        access(LW, 3'b0, 32'h440, 32'h0, r, m, c);
        chk("evicted440_cycles", c, 6);

        clear_mon();
        access(LW, 3'b0, 32'hC40, 32'h0, r, m, c);
        chk("dirty_rdata",   r, 32'hC3A50C40);
        chk("dirty_cycles",  c, 10);
        chk("dirty_wb_addr", wb_addr, 28'h004);
        chk("dirty_wb_data", wb_data, {32'h12345678, 32'hC3A50042, 32'hBEEF0041, 32'hC3A5AB40});
        chk("dirty_rd_addr", rd_addr, 28'h0C4);
        chk("dirty_order",   (first_wr_cyc >= 0) && (first_wr_cyc < first_rd_cyc), 1'b1);
        chk("dirty_wr_cyc",  wr_cycles, 4);
        chk("dirty_rd_cyc",  rd_cycles, 4);
        chk("dirty_overlap", overlap, 0);
        access(LW, 3'b0, 32'h40, 32'h0, r, m, c);
        chk("refetch40_cycles", c, 6);
        chk("refetch40_rdata",  r, 32'hC3A5AB40);
        access(LW, 3'b0, 32'h4C, 32'h0, r, m, c);
        chk("refetch4c_rdata",  r, 32'h12345678);

        read = LW; address = 32'h200;
        repeat (3) @(negedge clock);
        chk("pre_rst_mem_read", mem_read, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_fetch_mem_read", mem_read,  1'b0);
        chk("rst_fetch_busy",     busywait,  1'b0);
        chk("rst_fetch_rdata",    readdata,  32'h0);
        read = 4'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        access(LW, 3'b0, 32'h200, 32'h0, r, m, c);
        chk("after_rst_cycles", c, 6);
        chk("after_rst_rdata",  r, 32'hC3A50200);
        access(LW, 3'b0, 32'h40, 32'h0, r, m, c);
        chk("after_rst_40_miss", c, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
